pusch_bit_source: RTL and testbench

- Parametrised serial bit-stream source that feeds the 1-bit Data_in/enable input of the PUSCH chain from a word-wide host interface.
- Buffers WORD_W-bit words in a FIFO, serialises one transport block of tb_len bits, and pulses enable together with the first bit.
- Signals block completion and underrun.
- Replaces hand-driven Data_in/enable stimulus; sits directly in front of PUSCH_Top.

---
 rtl/pusch_bit_source.sv | 210 +++++++++++++++++++++
 tb/tb_pusch_bit_source.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pusch_bit_source.sv
// Word-to-bit serialiser feeding the PUSCH Data_in/enable inputs: buffers host
// words in a FIFO and streams one transport block of tb_len bits per tb_start.
module pusch_bit_source #(
   parameter int unsigned WORD_W     = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned LEN_W      = 17,
   parameter int unsigned MSB_FIRST  = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [WORD_W-1:0]                    s_data,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [LEN_W-1:0]                     tb_len,
   input  logic                                 tb_start,
   input  logic                                 abort,
   output logic                                 enable_out,
   output logic                                 bit_out,
   output logic                                 bit_valid,
   output logic                                 tb_done,
   output logic                                 busy,
   output logic                                 underrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);

   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned LW  = $clog2(FIFO_DEPTH+1);
   localparam int unsigned SCW = $clog2(WORD_W);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;

   logic [1:0]        state_q, state_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [SCW-1:0]    shcnt_q, shcnt_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic              underrun_q, underrun_d;
   logic              bit_out_q, bit_out_d;
   logic              bit_valid_q, bit_valid_d;
   logic              enable_q, enable_d;
   logic              tb_done_q, tb_done_d;

   logic              push;
   logic              pop;
   logic              emit;
   logic              fifo_empty;
   logic [WORD_W-1:0] src_word;

   // s_ready is held low while reset is asserted, independent of the level
   assign s_ready    = reset && (level_q < LW'(FIFO_DEPTH));
   assign push       = s_valid && s_ready && !abort;
   assign fifo_empty = (level_q == '0);

   assign enable_out = enable_q;
   assign bit_out    = bit_out_q;
   assign bit_valid  = bit_valid_q;
   assign tb_done    = tb_done_q;
   assign busy       = (state_q != S_IDLE);
   assign underrun   = underrun_q;
   assign fifo_level = level_q;

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      shcnt_d     = shcnt_q;
      remaining_d = remaining_q;
      underrun_d  = underrun_q;
      bit_out_d   = 1'b0;
      bit_valid_d = 1'b0;
      enable_d    = 1'b0;
      tb_done_d   = 1'b0;
      pop         = 1'b0;
      emit        = 1'b0;
      // shcnt_q counts bits still held in the shifter; zero means take the FIFO head
      src_word    = (shcnt_q != '0) ? shreg_q : mem[rd_ptr_q];

      case (state_q)
         S_IDLE: begin
            if (tb_start) begin
               shreg_d = '0;
               shcnt_d = '0;
               if (tb_len != '0) begin
                  remaining_d = tb_len;
                  underrun_d  = 1'b0;
                  state_d     = S_LOAD;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_LOAD: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               emit     = 1'b1;
               enable_d = 1'b1;
            end
         end
         S_STREAM: begin
            if (shcnt_q != '0) begin
               emit = 1'b1;
            end else if (!fifo_empty) begin
               pop  = 1'b1;
               emit = 1'b1;
            end else begin
               underrun_d = 1'b1;
            end
         end
         S_DONE: begin
            tb_done_d = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (emit) begin
         bit_valid_d = 1'b1;
         if (MSB_FIRST != 0) begin
            bit_out_d = src_word[WORD_W-1];
            shreg_d   = src_word << 1;
         end else begin
            bit_out_d = src_word[0];
            shreg_d   = src_word >> 1;
         end
         shcnt_d     = (shcnt_q != '0) ? shcnt_q - SCW'(1) : SCW'(WORD_W-1);
         remaining_d = remaining_q - LEN_W'(1);
         state_d     = (remaining_q == LEN_W'(1)) ? S_DONE : S_STREAM;
      end

      // abort overrides everything except the sticky underrun flag
      if (abort) begin
         state_d     = S_IDLE;
         shreg_d     = '0;
         shcnt_d     = '0;
         remaining_d = '0;
         underrun_d  = underrun_q;
         bit_out_d   = 1'b0;
         bit_valid_d = 1'b0;
         enable_d    = 1'b0;
         tb_done_d   = 1'b0;
         pop         = 1'b0;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (abort) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         shreg_q     <= '0;
         shcnt_q     <= '0;
         remaining_q <= '0;
         underrun_q  <= 1'b0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         enable_q    <= 1'b0;
         tb_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         shreg_q     <= shreg_d;
         shcnt_q     <= shcnt_d;
         remaining_q <= remaining_d;
         underrun_q  <= underrun_d;
         bit_out_q   <= bit_out_d;
         bit_valid_q <= bit_valid_d;
         enable_q    <= enable_d;
         tb_done_q   <= tb_done_d;
      end
   end

endmodule

// File: tb/tb_pusch_bit_source.sv
// Directed bench for pusch_bit_source: an MSB-first and an LSB-first instance
// share one stimulus stream; expected bit patterns are written out by hand.
module tb_pusch_bit_source;

   logic        clk;
   logic        reset;
   logic [7:0]  s_data;
   logic        s_valid;
   logic [16:0] tb_len;
   logic        tb_start;
   logic        abort;

   logic        s_ready, enable_out, bit_out, bit_valid, tb_done, busy, underrun;
   logic [4:0]  fifo_level;
   logic        l_s_ready, l_enable_out, l_bit_out, l_bit_valid, l_tb_done, l_busy, l_underrun;
   logic [4:0]  l_fifo_level;

   int total = 0;
   int bad   = 0;

   pusch_bit_source #(.WORD_W(8), .FIFO_DEPTH(16), .LEN_W(17), .MSB_FIRST(1)) dut (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .tb_len(tb_len), .tb_start(tb_start), .abort(abort), .enable_out(enable_out),
      .bit_out(bit_out), .bit_valid(bit_valid), .tb_done(tb_done), .busy(busy),
      .underrun(underrun), .fifo_level(fifo_level)
   );

   pusch_bit_source #(.WORD_W(8), .FIFO_DEPTH(16), .LEN_W(17), .MSB_FIRST(0)) dut_l (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(l_s_ready),
      .tb_len(tb_len), .tb_start(tb_start), .abort(abort), .enable_out(l_enable_out),
      .bit_out(l_bit_out), .bit_valid(l_bit_valid), .tb_done(l_tb_done), .busy(l_busy),
      .underrun(l_underrun), .fifo_level(l_fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // pat[n-1-i] / lpat[n-1-i] is the i-th emitted bit of the MSB / LSB instance
   task automatic expect_bits(input string tag, input logic [31:0] pat, input logic [31:0] lpat,
                              input int n, input bit first, input bit use_l);
      for (int i = 0; i < n; i++) begin
         tick();
         chk({tag, "_bv"}, bit_valid, 1);
         chk({tag, "_bit"}, bit_out, pat[n-1-i]);
         chk({tag, "_en"}, enable_out, (first && i == 0));
         if (use_l) begin
            chk({tag, "_lbv"}, l_bit_valid, 1);
            chk({tag, "_lbit"}, l_bit_out, lpat[n-1-i]);
            chk({tag, "_len"}, l_enable_out, (first && i == 0));
         end
      end
   endtask

   task automatic push_word(input logic [7:0] w);
      s_data  = w;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic start_block(input logic [16:0] len);
      tb_len   = len;
      tb_start = 1'b1;
      tick();
      tb_start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; s_data = '0; s_valid = 1'b0; tb_len = '0; tb_start = 1'b0; abort = 1'b0;
      #1 reset = 1'b0;
      #2;
      chk("rst_en", enable_out, 0);
      chk("rst_bit", bit_out, 0);
      chk("rst_bv", bit_valid, 0);
      chk("rst_done", tb_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_und", underrun, 0);
      chk("rst_lvl", fifo_level, 0);
      chk("rst_rdy", s_ready, 0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("rel_rdy", s_ready, 1);
      chk("rel_busy", busy, 0);

      // basic 16-bit block, first bit two cycles after the tb_start cycle
      push_word(8'hA5);
      push_word(8'h3C);
      chk("t1_lvl2", fifo_level, 2);
      start_block(17'd16);
      chk("t1_load_en", enable_out, 0);
      chk("t1_load_bv", bit_valid, 0);
      chk("t1_load_busy", busy, 1);
      expect_bits("t1", 32'hA53C, 32'hA53C, 16, 1'b1, 1'b1);
      tick();
      chk("t1_done", tb_done, 1);
      chk("t1_done_bv", bit_valid, 0);
      chk("t1_lvl0", fifo_level, 0);
      tick();
      chk("t1_done_off", tb_done, 0);
      chk("t1_idle", busy, 0);

      // leftover bits of the last word are not carried into the next block
      push_word(8'h01);
      start_block(17'd3);
      expect_bits("t2a", 32'b000, 32'b100, 3, 1'b1, 1'b1);
      tick();
      chk("t2a_done", tb_done, 1);
      chk("t2a_ldone", l_tb_done, 1);
      push_word(8'hFF);
      start_block(17'd2);
      expect_bits("t2b", 32'b11, 32'b11, 2, 1'b1, 1'b1);
      tick();
      chk("t2b_ldone", l_tb_done, 1);
      chk("t2b_llvl", l_fifo_level, 0);

      // underrun: 20 bits from 2 words, third word arrives late
      push_word(8'hF0);
      push_word(8'h0F);
      start_block(17'd20);
      expect_bits("t3a", 32'hF00F, 32'h0FF0, 16, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_gap_bv", bit_valid, 0);
         chk("t3_gap_bit", bit_out, 0);
         chk("t3_und", underrun, 1);
         if (i == 3) begin
            s_data  = 8'hA0;
            s_valid = 1'b1;
         end
         if (i == 4) s_valid = 1'b0;
      end
      expect_bits("t3b", 32'hA, 32'h0, 4, 1'b0, 1'b1);
      tick();
      chk("t3_done", tb_done, 1);
      chk("t3_und_sticky", underrun, 1);
      start_block(17'd8);
      chk("t3_und_clr", underrun, 0);
      tick();
      chk("t3_load_wait_bv", bit_valid, 0);
      chk("t3_load_no_und", underrun, 0);
      chk("t3_load_busy", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t3_abort_busy", busy, 0);
      tick();
      chk("t3_abort_nodone", tb_done, 0);

      // overfill: 18 words offered, only 16 stored
      for (int i = 0; i < 18; i++) begin
         s_data  = 8'(i + 1);
         s_valid = 1'b1;
         tick();
         chk("t4_lvl", fifo_level, (i + 1 < 16) ? i + 1 : 16);
         chk("t4_rdy", s_ready, (i + 1 < 16) ? 1 : 0);
      end
      s_valid = 1'b0;
      start_block(17'd8);
      chk("t4_full_rdy", s_ready, 0);
      expect_bits("t4", 32'h01, 32'h80, 8, 1'b1, 1'b1);
      chk("t4_lvl15", fifo_level, 15);
      chk("t4_rdy_back", s_ready, 1);
      tick();
      chk("t4_done", tb_done, 1);

      // zero-length block, then tb_start ignored during STREAM
      start_block(17'd0);
      chk("t5_zero_busy", busy, 1);
      chk("t5_zero_en", enable_out, 0);
      chk("t5_zero_bv", bit_valid, 0);
      tick();
      chk("t5_zero_done", tb_done, 1);
      chk("t5_zero_en2", enable_out, 0);
      chk("t5_zero_bv2", bit_valid, 0);
      tick();
      chk("t5_zero_done_off", tb_done, 0);
      start_block(17'd16);
      expect_bits("t5a", 32'h0, 32'h0, 4, 1'b1, 1'b0);
      tb_len   = 17'd5;
      tb_start = 1'b1;
      expect_bits("t5b", 32'h0, 32'h0, 1, 1'b0, 1'b0);
      tb_start = 1'b0;
      expect_bits("t5c", 32'h203, 32'h0, 11, 1'b0, 1'b0);
      tick();
      chk("t5_done", tb_done, 1);
      chk("t5_lvl13", fifo_level, 13);

      // abort mid-STREAM, colliding with tb_start and a push
      start_block(17'd16);
      expect_bits("t6a", 32'h0, 32'h0, 3, 1'b1, 1'b0);
      abort    = 1'b1;
      tb_start = 1'b1;
      tb_len   = 17'd8;
      s_data   = 8'h77;
      s_valid  = 1'b1;
      tick();
      abort = 1'b0; tb_start = 1'b0; s_valid = 1'b0;
      chk("t6_busy", busy, 0);
      chk("t6_lvl", fifo_level, 0);
      chk("t6_bv", bit_valid, 0);
      tick();
      chk("t6_nodone", tb_done, 0);
      chk("t6_busy2", busy, 0);
      chk("t6_lvl2", fifo_level, 0);
      push_word(8'hC3);
      start_block(17'd8);
      expect_bits("t6b", 32'hC3, 32'hC3, 8, 1'b1, 1'b1);
      tick();
      chk("t6b_done", tb_done, 1);

      // reset pulled mid-STREAM
      push_word(8'h96);
      push_word(8'h69);
      start_block(17'd16);
      expect_bits("t7a", 32'h4, 32'h0, 3, 1'b1, 1'b0);
      reset = 1'b0;
      #2;
      chk("t7_busy", busy, 0);
      chk("t7_lvl", fifo_level, 0);
      chk("t7_bv", bit_valid, 0);
      chk("t7_rdy", s_ready, 0);
      tick();
      reset = 1'b1;
      tick();
      chk("t7_nodone", tb_done, 0);
      chk("t7_rdy2", s_ready, 1);
      push_word(8'h3C);
      start_block(17'd8);
      expect_bits("t7b", 32'h3C, 32'h3C, 8, 1'b1, 1'b1);
      tick();
      chk("t7b_done", tb_done, 1);
      chk("t7b_lvl", fifo_level, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
